muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit and its control FSM for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage and is launched when the decoder flags an R-type instruction with funct7 = 0000001.
- Holds the pipeline with a stall output until the result is ready; produces one result per launch.

---
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand/result bundle between the execute stage and the
// iterative RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, sign handling around the magnitude core.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   result;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic            launch;
    logic            last_step;
    logic            a_signed;
    logic            b_signed;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_val;

    assign launch    = (state == IDLE) && bus.start && !bus.flush;
    assign last_step = (cnt == CW'(XLEN - 1));
    assign a_signed  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign div_zero  = op[2] && (b == '0);
    assign div_ovf   = ((op == 3'b100) || (op == 3'b110)) &&
                       (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign special   = div_zero || div_ovf;
    // Divide by zero keeps the dividend for REM; overflow yields the dividend for DIV.
    assign special_val = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // Multiply step: low half holds the remaining multiplier bits, high half the partial sum.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_step;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_step  = {mul_sum, acc[XLEN-1:1]};
    assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
    assign div_step  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod    = cond_neg_wide(acc, sign_a ^ sign_b);
        fix_val = '0;
        if (!op[2])
            fix_val = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (op[1])
            fix_val = cond_neg(acc[2*XLEN-1:XLEN], sign_a);
        else
            fix_val = cond_neg(acc[XLEN-1:0], sign_a ^ sign_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = PREP;
            PREP:    state_next = special ? DONE : CALC;
            CALC:    if (last_step) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush && (state != IDLE))
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= '0;
            a      <= '0;
            b      <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        op <= bus.funct3;
                        a  <= bus.op_a;
                        b  <= bus.op_b;
                    end
                end
                PREP: begin
                    sign_a <= a_signed && a[XLEN-1];
                    sign_b <= b_signed && b[XLEN-1];
                    mag_a  <= cond_neg(a, a_signed && a[XLEN-1]);
                    mag_b  <= cond_neg(b, b_signed && b[XLEN-1]);
                    acc    <= {{XLEN{1'b0}},
                               op[2] ? cond_neg(a, a_signed && a[XLEN-1])
                                     : cond_neg(b, b_signed && b[XLEN-1])};
                    cnt    <= '0;
                    if (special && !bus.flush)
                        result <= special_val;
                end
                CALC: begin
                    acc <= op[2] ? div_step : mul_step;
                    if (!last_step)
                        cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!bus.flush)
                        result <= fix_val;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == PREP) || (state == CALC) || (state == FIX);
    assign bus.stall  = bus.busy || launch;
    assign bus.done   = (state == DONE);
    assign bus.result = result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a plain
// arithmetic model of the RV32M multiply/divide results.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [XLEN-1:0] last_exp;

    muldiv_sequencer_if #(.XLEN(XLEN)) mif ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        r  = '0;
        case (f)
            3'd0: begin p = 64'(ux * uy); r = p[31:0];  end
            3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
            3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
            3'd3: begin p = 64'(ux * uy); r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else r = 32'(sx / sy);
            end
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(sx % sy);
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && y == 0) return 1'b1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] exp;
        int exp_lat, lat, done_cnt, stall_err, launch_ok;
        exp      = ref_model(f, x, y);
        exp_lat  = is_special(f, x, y) ? 2 : XLEN + 3;
        lat      = -1;
        done_cnt = 0;
        stall_err = 0;
        @(negedge clk);
        mif.start  = 1'b1;
        mif.funct3 = f;
        mif.op_a   = x;
        mif.op_b   = y;
        #1;
        launch_ok = (mif.stall === 1'b1 && mif.done === 1'b0) ? 1 : 0;
        @(negedge clk);
        mif.start  = 1'b0;
        mif.funct3 = 3'($urandom);
        mif.op_a   = $urandom;
        mif.op_b   = $urandom;
        for (int cyc = 1; cyc <= exp_lat + 3; cyc++) begin
            if (mif.done === 1'b1) begin
                done_cnt++;
                if (lat < 0) lat = cyc;
                if (mif.stall !== 1'b0 || mif.busy !== 1'b0) stall_err++;
            end else if (lat < 0) begin
                if (mif.stall !== 1'b1 || mif.busy !== 1'b1) stall_err++;
            end
            if (cyc < exp_lat + 3) @(negedge clk);
        end
        check({tag, " result"}, mif.result, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " stall/busy"}, 32'(stall_err + (1 - launch_ok)), 32'd0);
        last_exp = exp;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int dones;
        total = 0;
        bad = 0;
        last_exp = '0;
        rst_n = 1'b0;
        mif.start = 1'b0;
        mif.flush = 1'b0;
        mif.funct3 = '0;
        mif.op_a = '0;
        mif.op_b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(mif.busy), 32'd0);
        check("reset stall", 32'(mif.stall), 32'd0);
        check("reset done", 32'(mif.done), 32'd0);
        check("reset result", mif.result, 32'd0);
        rst_n = 1'b1;

        do_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD);
        do_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000);
        do_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op("DIVU", 3'd5, 32'd100, 32'd7);
        do_op("REMU", 3'd7, 32'd100, 32'd7);
        do_op("DIVU0", 3'd5, 32'd5, 32'd0);
        do_op("REM0", 3'd6, 32'd5, 32'd0);
        do_op("DIVOVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("REMOVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb);
        end

        // Flush and start together in IDLE: no launch.
        @(negedge clk);
        mif.start = 1'b1;
        mif.flush = 1'b1;
        mif.funct3 = 3'd0;
        #1;
        check("flush+start stall", 32'(mif.stall), 32'd0);
        @(negedge clk);
        mif.start = 1'b0;
        mif.flush = 1'b0;
        check("flush+start busy", 32'(mif.busy), 32'd0);

        // Flush ten cycles into CALC.
        @(negedge clk);
        mif.start = 1'b1;
        mif.funct3 = 3'd3;
        mif.op_a = 32'h1234_5678;
        mif.op_b = 32'h9ABC_DEF0;
        dones = 0;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (11) begin
            if (mif.done === 1'b1) dones++;
            @(negedge clk);
        end
        mif.flush = 1'b1;
        @(negedge clk);
        mif.flush = 1'b0;
        check("flush busy", 32'(mif.busy), 32'd0);
        check("flush stall", 32'(mif.stall), 32'd0);
        repeat (40) begin
            if (mif.done === 1'b1) dones++;
            @(negedge clk);
        end
        check("flush no done", 32'(dones), 32'd0);
        check("flush result kept", mif.result, last_exp);
        do_op("after flush", 3'd4, 32'hFFFF_FF00, 32'd7);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        mif.start = 1'b1;
        mif.funct3 = 3'd0;
        mif.op_a = 32'd99;
        mif.op_b = 32'd77;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(mif.busy), 32'd0);
        check("async rst stall", 32'(mif.stall), 32'd0);
        check("async rst done", 32'(mif.done), 32'd0);
        check("async rst result", mif.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("MUL after rst", 3'd0, 32'd3, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
